addn_serial: RTL

Parametrised, digit-serial two's-complement adder/subtractor, the multi-cycle successor to the team's 2-bit combinational adder. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock and exposes a start/busy/done handshake. It returns a registered sum with carry-out and signed-overflow flags. It sits in the combinational/arithmetic library and is the reusable adder for datapaths that trade latency for area.

---
 rtl/add_pkg.sv | 20 ++
 rtl/add_digit.sv | 26 ++
 rtl/addn_serial.sv | 117 +++++++++++
 3 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding and a
// constant-width helper.
package add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/add_digit.sv
// DIGIT-bit ripple-carry adder; also exposes the carry into its top bit so the
// caller can derive signed overflow.
module add_digit #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_s,
  output logic             o_cout,
  output logic             o_c_msb_in
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout     = w_c[DIGIT];
  assign o_c_msb_in = w_c[DIGIT-1];

endmodule

// File: rtl/addn_serial.sv
// Digit-serial two's-complement adder/subtractor: WIDTH-bit operands processed
// DIGIT bits per clock, start/busy/done handshake, registered sum/cout/ovf.
module addn_serial
  import add_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_add_in1,
  input  logic [WIDTH-1:0] i_add_in0,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = clog2(NDIG) + 1;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT-1:0] w_s;
  logic [WIDTH-1:0] w_s_ext;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_cout;
  logic             w_c_msb;
  logic             w_accept;
  logic             w_last;

  add_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .i_a       (r_a[DIGIT-1:0]),
    .i_b       (r_b[DIGIT-1:0]),
    .i_cin     (r_carry),
    .o_s       (w_s),
    .o_cout    (w_cout),
    .o_c_msb_in(w_c_msb)
  );

  assign w_accept = i_start && (r_state != ST_RUN);
  assign w_last   = (r_cnt == CW'(NDIG - 1));

  // New digit enters at the MSB end; after NDIG shifts the LSB digit sits at bit 0.
  assign w_s_ext    = WIDTH'(w_s);
  assign w_acc_next = (r_acc >> DIGIT) | (w_s_ext << (WIDTH - DIGIT));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (i_start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = i_start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction as A + ~B + 1: invert B here, seed the carry with sub.
      r_a     <= i_add_in1;
      r_b     <= i_add_in0 ^ {WIDTH{i_sub}};
      r_acc   <= '0;
      r_carry <= i_sub;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_acc   <= w_acc_next;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_cout;
        r_ovf  <= w_c_msb ^ w_cout;
      end
    end
  end

  assign o_busy = (r_state == ST_RUN);
  assign o_done = (r_state == ST_DONE);
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule
